nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_pkg.sv | 12 +
 rtl/nibble_dec.sv | 13 +
 rtl/nibble_packer.sv | 77 +++++++
 tb/tb_nibble_packer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared widths and state encoding for the nibble packer
package nibble_pkg;
   localparam int NIBBLE_W  = 4;
   localparam int NUM_SLOTS = 4;
   localparam int WORD_W    = 16;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;
endpackage

// File: rtl/nibble_dec.sv
// rtl/nibble_dec.sv - slot index to one-hot write enable, gated by en
import nibble_pkg::*;

module nibble_dec (
   input  logic [SLOT_W-1:0]    idx,
   input  logic                 en,
   output logic [NUM_SLOTS-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end
endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - assembles four nibbles into a held 16-bit word
import nibble_pkg::*;

module nibble_packer (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NIBBLE_W-1:0]  nibble_in,
   input  logic                 nibble_valid,
   output logic                 nibble_ready,
   input  logic                 mode,
   input  logic [SLOT_W-1:0]    sel,
   input  logic                 clear,
   output logic [WORD_W-1:0]    word_out,
   output logic                 word_valid,
   input  logic                 word_ack,
   output logic [NUM_SLOTS-1:0] written_mask
);
   state_t                state, next_state;
   logic [SLOT_W-1:0]     ptr;
   logic [SLOT_W-1:0]     slot;
   logic                  accept;
   logic [NUM_SLOTS-1:0]  we;
   logic [NUM_SLOTS-1:0]  mask_next;

   assign nibble_ready = (state == FILL);
   assign word_valid   = (state == FULL);
   assign accept       = nibble_valid && nibble_ready;
   assign slot         = mode ? sel : ptr;
   assign mask_next    = written_mask | we;

   nibble_dec u_dec (
      .idx    (slot),
      .en     (accept),
      .onehot (we)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FILL: begin
            if (!clear && accept && mask_next == {NUM_SLOTS{1'b1}})
               next_state = FULL;
         end
         FULL: begin
            if (clear || word_ack) next_state = FILL;
         end
         default: next_state = FILL;
      endcase
   end

   // clear wins over an in-flight nibble; word_out is never touched by clear or ack
   always_ff @(posedge clk) begin
      if (rst) begin
         word_out     <= '0;
         written_mask <= '0;
         ptr          <= '0;
      end else if (clear) begin
         written_mask <= '0;
         ptr          <= '0;
      end else if (state == FILL) begin
         if (accept) begin
            for (int i = 0; i < NUM_SLOTS; i++)
               if (we[i]) word_out[i*NIBBLE_W +: NIBBLE_W] <= nibble_in;
            written_mask <= mask_next;
            if (!mode) ptr <= ptr + 2'd1;
         end
      end else if (word_ack) begin
         written_mask <= '0;
         ptr          <= '0;
      end
   end
endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - scoreboard bench for nibble_packer
module tb_nibble_packer;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  nibble_in;
   logic        nibble_valid;
   logic        nibble_ready;
   logic        mode;
   logic [1:0]  sel;
   logic        clear;
   logic [15:0] word_out;
   logic        word_valid;
   logic        word_ack;
   logic [3:0]  written_mask;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   logic        seen_valid = 1'b0;

   always #5 clk = ~clk;

   nibble_packer dut (
      .clk          (clk),
      .rst          (rst),
      .nibble_in    (nibble_in),
      .nibble_valid (nibble_valid),
      .nibble_ready (nibble_ready),
      .mode         (mode),
      .sel          (sel),
      .clear        (clear),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ack     (word_ack),
      .written_mask (written_mask)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Each completed word is compared once, on its first cycle of word_valid.
   initial begin
      forever begin
         @(negedge clk);
         if (word_valid && !seen_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word actual=%0h expected=none", word_out);
            end else begin
               check("sb_word", {16'h0, word_out}, {16'h0, exp_q.pop_front()});
            end
         end
         seen_valid = word_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic m, input logic [1:0] s, input logic [3:0] n);
      mode = m; sel = s; nibble_in = n; nibble_valid = 1'b1;
      step();
      nibble_valid = 1'b0;
   endtask

   task automatic ack();
      word_ack = 1'b1;
      step();
      word_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; nibble_in = '0; nibble_valid = 1'b0; mode = 1'b0;
      sel = '0; clear = 1'b0; word_ack = 1'b0;
      step();
      rst = 1'b0;
      check("rst_word", word_out, 16'h0000);
      check("rst_valid", word_valid, 1'b0);
      check("rst_ready", nibble_ready, 1'b1);
      check("rst_mask", written_mask, 4'b0000);

      // Mode 0 fill
      exp_q.push_back(16'h4321);
      wr(0, 0, 4'h1); wr(0, 0, 4'h2); wr(0, 0, 4'h3);
      check("m0_ready_before_last", nibble_ready, 1'b1);
      wr(0, 0, 4'h4);
      check("m0_word", word_out, 16'h4321);
      check("m0_valid", word_valid, 1'b1);
      check("m0_ready", nibble_ready, 1'b0);
      ack();
      check("ack1_valid", word_valid, 1'b0);
      check("ack1_mask", written_mask, 4'b0000);

      // Mode 1 with overwrite
      exp_q.push_back(16'hCEDB);
      wr(1, 3, 4'hA); check("m1_mask0", written_mask, 4'b1000);
      wr(1, 0, 4'hB); check("m1_mask1", written_mask, 4'b1001);
      wr(1, 3, 4'hC); check("m1_mask2", written_mask, 4'b1001);
      check("m1_valid_overwrite", word_valid, 1'b0);
      wr(1, 1, 4'hD); check("m1_mask3", written_mask, 4'b1011);
      wr(1, 2, 4'hE); check("m1_mask4", written_mask, 4'b1111);
      check("m1_word", word_out, 16'hCEDB);

      // nibbles ignored in FULL
      mode = 1'b0; nibble_in = 4'hF; nibble_valid = 1'b1;
      step(); step(); step();
      nibble_valid = 1'b0;
      check("full_hold_word", word_out, 16'hCEDB);
      check("full_hold_valid", word_valid, 1'b1);
      check("full_hold_mask", written_mask, 4'b1111);
      ack();
      check("ack2_word", word_out, 16'hCEDB);
      check("ack2_valid", word_valid, 1'b0);
      check("ack2_mask", written_mask, 4'b0000);
      check("ack2_ready", nibble_ready, 1'b1);

      // clear beats a simultaneous nibble
      wr(0, 0, 4'h5); wr(0, 0, 4'h6);
      check("pre_clear_mask", written_mask, 4'b0011);
      clear = 1'b1;
      wr(0, 0, 4'h7);
      clear = 1'b0;
      check("clear_mask", written_mask, 4'b0000);
      check("clear_ptr", dut.ptr, 2'd0);
      check("clear_word", word_out, 16'hCE65);
      wr(0, 0, 4'h9);
      check("post_clear_word", word_out, 16'hCE69);
      check("post_clear_mask", written_mask, 4'b0001);

      // reset while FULL, with ack and clear also asserted
      clear = 1'b1; step(); clear = 1'b0;
      exp_q.push_back(16'hBEEF);
      wr(0, 0, 4'hF); wr(0, 0, 4'hE); wr(0, 0, 4'hE); wr(0, 0, 4'hB);
      check("beef_valid", word_valid, 1'b1);
      check("beef_word", word_out, 16'hBEEF);
      rst = 1'b1; word_ack = 1'b1; clear = 1'b1;
      step();
      rst = 1'b0; word_ack = 1'b0; clear = 1'b0;
      check("rst_full_word", word_out, 16'h0000);
      check("rst_full_valid", word_valid, 1'b0);
      check("rst_full_ready", nibble_ready, 1'b1);

      // mixed modes: mode-1 write completes word and leaves ptr at 3
      exp_q.push_back(16'h4321);
      wr(0, 0, 4'h1); wr(0, 0, 4'h2); wr(0, 0, 4'h3);
      check("mix_ptr3", dut.ptr, 2'd3);
      wr(1, 3, 4'h4);
      check("mix_valid", word_valid, 1'b1);
      check("mix_ptr_full", dut.ptr, 2'd3);
      step();
      check("mix_ptr_hold", dut.ptr, 2'd3);
      ack();
      check("mix_ptr_ack", dut.ptr, 2'd0);

      // word_ack in FILL does nothing
      wr(0, 0, 4'hA);
      ack();
      check("fill_ack_mask", written_mask, 4'b0001);
      check("fill_ack_ptr", dut.ptr, 2'd1);
      check("fill_ack_ready", nibble_ready, 1'b1);

      // clear while FULL
      exp_q.push_back(16'h321A);
      wr(0, 0, 4'h1); wr(0, 0, 4'h2); wr(0, 0, 4'h3);
      check("clr_full_valid", word_valid, 1'b1);
      clear = 1'b1; step(); clear = 1'b0;
      check("clr_full_state", word_valid, 1'b0);
      check("clr_full_word", word_out, 16'h321A);

      step();
      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
